// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, LSB-first data, optional parity and
// stop, and steers the downstream TX output mux one bit per clock.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic                  par_en_r;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      IDLE:    return 2'b01;
      START:   return 2'b00;
      DATA:    return 2'b10;
      PARITY:  return 2'b11;
      STOP:    return 2'b01;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic busy_of(input state_t s);
    case (s)
      START, DATA, PARITY, STOP: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a new byte is only taken while the line sits at stop/idle level.
  always_comb begin
    state_s  = IDLE;
    accept_s = 1'b0;
    case (state_r)
      IDLE, STOP: begin
        if (data_valid) begin
          accept_s = 1'b1;
          state_s  = START;
        end else begin
          state_s  = IDLE;
        end
      end
      START: state_s = DATA;
      DATA: begin
        if (bit_cnt_r == LAST_CNT) begin
          if (par_en_r) begin
            state_s = PARITY;
          end else begin
            state_s = STOP;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY:  state_s = STOP;
      default: state_s = IDLE;
    endcase
  end

  // Frame datapath: latch on acceptance, shift out one bit per DATA cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= {DATA_WIDTH{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      par_en_r  <= 1'b0;
      par_bit   <= 1'b0;
    end else if (accept_s) begin
      shift_r   <= p_data;
      bit_cnt_r <= {CNT_W{1'b0}};
      par_en_r  <= par_en;
      par_bit   <= calc_parity(p_data, par_typ);
    end else if (state_r == DATA) begin
      shift_r   <= shift_r >> 1;
      bit_cnt_r <= bit_cnt_r + CNT_W'(1);
    end else if (state_r == START) begin
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Mux select and busy are registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mux_sel <= 2'b01;
      busy    <= 1'b0;
    end else begin
      mux_sel <= sel_of(state_s);
      busy    <= busy_of(state_s);
    end
  end

  assign ser_data = shift_r[0];

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm with a registered TX mux model downstream.
module tb_uart_tx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       par_bit;
  logic       busy;
  logic       tx_out;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .mux_sel(mux_sel),
    .ser_data(ser_data), .par_bit(par_bit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Downstream output mux: line follows mux_sel one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_out <= 1'b1;
    else begin
      case (mux_sel)
        2'b00:   tx_out <= 1'b0;
        2'b01:   tx_out <= 1'b1;
        2'b10:   tx_out <= ser_data;
        default: tx_out <= par_bit;
      endcase
    end
  end

  // Caller has just raised data_valid at a negedge. Walks the whole frame checking every cycle.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic pe,
                           input logic exp_par, input logic hold, input logic [7:0] next_data,
                           input int pulse_at);
    int len;
    logic [1:0] exp_sel;
    logic exp_line;
    logic prev_line;
    len = 10 + int'(pe);
    prev_line = 1'b1;
    for (int s = 0; s < len; s++) begin
      @(negedge clk);
      if (s == 0) begin
        if (hold) begin
          p_data = next_data;
        end else begin
          data_valid = 1'b0;
          p_data = ~data;
          par_en = ~pe;
          par_typ = ~par_typ;
        end
      end
      if (s == pulse_at) begin
        data_valid = 1'b1;
        p_data = 8'hFF;
      end else if (s == pulse_at + 1) begin
        data_valid = 1'b0;
      end
      if (s == 0) begin
        exp_sel = 2'b00; exp_line = 1'b0;
      end else if (s <= 8) begin
        exp_sel = 2'b10; exp_line = data[s-1];
      end else if (pe && s == 9) begin
        exp_sel = 2'b11; exp_line = exp_par;
      end else begin
        exp_sel = 2'b01; exp_line = 1'b1;
      end
      vectors++;
      if (mux_sel !== exp_sel) begin
        miscompares++;
        $display("FAIL %s mux_sel step %0d: got %b want %b", tag, s, mux_sel, exp_sel);
      end
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s busy step %0d: got %b want 1", tag, s, busy);
      end
      vectors++;
      if (par_bit !== exp_par) begin
        miscompares++;
        $display("FAIL %s par_bit step %0d: got %b want %b", tag, s, par_bit, exp_par);
      end
      vectors++;
      if (tx_out !== prev_line) begin
        miscompares++;
        $display("FAIL %s tx_out step %0d: got %b want %b", tag, s, tx_out, prev_line);
      end
      if (exp_sel == 2'b10) begin
        vectors++;
        if (ser_data !== exp_line) begin
          miscompares++;
          $display("FAIL %s ser_data step %0d: got %b want %b", tag, s, ser_data, exp_line);
        end
      end
      prev_line = exp_line;
    end
    if (!hold) begin
      @(negedge clk);
      vectors++;
      if (mux_sel !== 2'b01 || busy !== 1'b0 || tx_out !== 1'b1) begin
        miscompares++;
        $display("FAIL %s idle after frame: got sel=%b busy=%b tx=%b want sel=01 busy=0 tx=1",
                 tag, mux_sel, busy, tx_out);
      end
    end
  endtask

  task automatic start_req(input logic [7:0] data, input logic pe, input logic pt);
    p_data = data; par_en = pe; par_typ = pt; data_valid = 1'b1;
  endtask

  task automatic test_reset();
    data_valid = 1'b1;
    p_data = 8'hA5;
    repeat (2) @(negedge clk);
    vectors++;
    if (mux_sel !== 2'b01 || busy !== 1'b0 || par_bit !== 1'b0 || ser_data !== 1'b0 || tx_out !== 1'b1) begin
      miscompares++;
      $display("FAIL reset values: got sel=%b busy=%b par=%b ser=%b tx=%b want 01 0 0 0 1",
               mux_sel, busy, par_bit, ser_data, tx_out);
    end
    data_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (mux_sel !== 2'b01 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset idle after release: got sel=%b busy=%b want 01 0", mux_sel, busy);
    end
  endtask

  task automatic test_parity_even();
    start_req(8'hA5, 1'b1, 1'b0);
    run_frame("even_A5", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, -10);
  endtask

  task automatic test_parity_odd();
    start_req(8'hA5, 1'b1, 1'b1);
    run_frame("odd_A5", 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, -10);
    start_req(8'h07, 1'b1, 1'b0);
    run_frame("even_07", 8'h07, 1'b1, 1'b1, 1'b0, 8'h00, -10);
  endtask

  task automatic test_no_parity();
    start_req(8'hFF, 1'b0, 1'b0);
    run_frame("nopar_FF", 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, -10);
  endtask

  task automatic test_back_to_back();
    start_req(8'h3C, 1'b1, 1'b1);
    run_frame("b2b_3C", 8'h3C, 1'b1, 1'b1, 1'b1, 8'hC3, -10);
    run_frame("b2b_C3", 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00, -10);
  endtask

  task automatic test_ignore_and_reset();
    start_req(8'h5A, 1'b0, 1'b0);
    run_frame("ignore_5A", 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 3);
    start_req(8'h81, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    data_valid = 1'b0;
    vectors++;
    if (mux_sel !== 2'b10) begin
      miscompares++;
      $display("FAIL midframe in DATA: got sel=%b want 10", mux_sel);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (mux_sel !== 2'b01 || busy !== 1'b0 || par_bit !== 1'b0 || ser_data !== 1'b0 || tx_out !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe reset: got sel=%b busy=%b par=%b ser=%b tx=%b want 01 0 0 0 1",
               mux_sel, busy, par_bit, ser_data, tx_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (mux_sel !== 2'b01 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no resume after reset: got sel=%b busy=%b want 01 0", mux_sel, busy);
    end
    start_req(8'h07, 1'b1, 1'b0);
    run_frame("post_reset_07", 8'h07, 1'b1, 1'b1, 1'b0, 8'h00, -10);
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_no_parity();
    test_back_to_back();
    test_ignore_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
